eth_tx_frame_assemble: RTL and testbench
========================================

// Module: eth_tx_frame_assemble
// PURPOSE
// - TX-side counterpart of the RX Ethernet frame parser.
// - Accepts an eth_hdr (dst MAC, src MAC, ethertype) plus a payload stream, and emits one
//   MAC-interface stream with the 14-byte header prepended to the payload.
// - Sits in the eth TX tile between the NoC-in/unpack logic and the MAC-side NoC-out block.
// PARAMETERS
// - DATA_W       default `MAC_INTERFACE_W (512)   stream width in bits; BYTES = DATA_W/8
// - SIZE_W       default `MTU_SIZE_W (16)         payload/frame size width in bytes
// - PAD_W        default `MAC_PADBYTES_W          width of padbytes, = $clog2(BYTES)
// - HDR_W        fixed 112                        eth_hdr width (HDR_B = 14 bytes)
// PORTS
// - clk                            in   1       clock
// - rst                            in   1       synchronous, active-high reset
// - src_eth_assemble_hdr_val       in   1       header valid
// - src_eth_assemble_eth_hdr       in   HDR_W   {dst_mac, src_mac, ethertype}
// - src_eth_assemble_data_size     in   SIZE_W  payload bytes, excluding header
// - eth_assemble_src_hdr_rdy       out  1       header accepted
// - src_eth_assemble_data_val      in   1       payload beat valid
// - src_eth_assemble_data          in   DATA_W  payload beat; byte 0 at MSBs
// - src_eth_assemble_data_last     in   1       final payload beat
// - src_eth_assemble_data_padbytes in   PAD_W   invalid LSB bytes of last beat
// - eth_assemble_src_data_rdy      out  1       payload beat accepted
// - eth_assemble_dst_val           out  1       frame beat valid
// - eth_assemble_dst_data          out  DATA_W  frame beat; byte 0 at MSBs
// - eth_assemble_dst_frame_size    out  SIZE_W  data_size+14; held for the whole frame
// - eth_assemble_dst_data_last     out  1       final frame beat
// - eth_assemble_dst_data_padbytes out  PAD_W   invalid LSB bytes of final beat
// - dst_eth_assemble_rdy           in   1       downstream ready
// BEHAVIOUR
// - Handshake: val/rdy on all three interfaces; transfer when val&&rdy. Valid never depends on rdy.
// - Reset (rst=1): all out val/rdy = 0; data/size/padbytes outputs = 0; FSM -> IDLE;
//   any partial frame is dropped, with no flush beat.
// - IDLE: hdr_rdy=1, data_rdy=0, dst_val=0.
//   - On hdr handshake: latch hdr into hdr_r and data_size into size_r.
//   - size=0 -> ZERO; else -> FIRST.
// - FIRST: dst_val = data_val.
//   - dst_data = {hdr_r, in[DATA_W-1:HDR_W]}.
// - MID: dst_val = data_val.
//   - dst_data = {carry_r, in[DATA_W-1:HDR_W]}.
// - FIRST/MID, common rules:
//   - data_rdy = dst_rdy; output is combinational, zero-cycle from input beat.
//   - On handshake: carry_r <= in[HDR_W-1:0].
//   - Non-last beat: -> MID.
//   - Last beat with pad_in >= 14: dst_last=1, dst_pad = pad_in-14, -> IDLE.
//   - Last beat with pad_in < 14: dst_last=0, -> DRAIN.
// - DRAIN: data_rdy=0, dst_val=1.
//   - dst_data = {carry_r, {DATA_W-HDR_W{1'b0}}}.
//   - dst_last=1, dst_pad = pad_in_r + BYTES - 14 (pad_in_r = latched last-beat pad).
//   - -> IDLE on dst handshake.
// - ZERO: dst_val=1, data consumes nothing.
//   - dst_data = {hdr_r, 0}, last=1, pad = BYTES-14.
//   - -> IDLE on dst handshake.
// - dst_frame_size = size_r+14, computed mod 2^SIZE_W, no saturation.
// - No runt padding to 60B; the MAC pads short frames.
// - Framing is governed by data_last; data_size is used for frame_size only and is not checked.
// - Min one bubble cycle between frames: header is accepted in IDLE only, so a hdr and data
//   beat offered in the same cycle accept only the hdr.
// - With dst_rdy low, all dst outputs hold stable; carry_r/state unchanged.
// - dst_last/dst_pad are 0 on non-last beats.
// TESTING (DATA_W=512, BYTES=64)
// - size=50, 1 beat pad=14 -> 1 out beat {hdr,in[511:112]}, last, pad=0, frame_size=64.
// - size=64, 1 beat pad=0 -> 2 beats; beat2 = {in[111:0],0}, last, pad=50, frame_size=78.
// - size=0 -> 1 beat {hdr,0}, last, pad=50; data_rdy never asserted.
// - size=200, 4 beats, last pad=56 -> 4 out beats, last pad=42, frame_size=214, no DRAIN.
// - Random dst_rdy stalls, back-to-back frames, hdr+data same cycle -> byte-exact vs model,
//   outputs stable under stall.
// - rst asserted mid-frame (in MID) -> next cycle dst_val=0, hdr_rdy=1; next frame correct.

Source files
------------

// File: rtl/eth_tx_frame_assemble.sv
// Prepends a 14-byte Ethernet header to a payload stream, realigning payload
// bytes across beat boundaries and emitting one MAC-side frame stream.
module eth_tx_frame_assemble #(
  parameter int DATA_W = 512,
  parameter int SIZE_W = 16,
  parameter int PAD_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_eth_assemble_hdr_val,
  input  logic [111:0]      src_eth_assemble_eth_hdr,
  input  logic [SIZE_W-1:0] src_eth_assemble_data_size,
  output logic              eth_assemble_src_hdr_rdy,
  input  logic              src_eth_assemble_data_val,
  input  logic [DATA_W-1:0] src_eth_assemble_data,
  input  logic              src_eth_assemble_data_last,
  input  logic [PAD_W-1:0]  src_eth_assemble_data_padbytes,
  output logic              eth_assemble_src_data_rdy,
  output logic              eth_assemble_dst_val,
  output logic [DATA_W-1:0] eth_assemble_dst_data,
  output logic [SIZE_W-1:0] eth_assemble_dst_frame_size,
  output logic              eth_assemble_dst_data_last,
  output logic [PAD_W-1:0]  eth_assemble_dst_data_padbytes,
  input  logic              dst_eth_assemble_rdy
);
  localparam int HDR_W = 112;
  localparam int HDR_B = HDR_W / 8;
  localparam int BYTES = DATA_W / 8;
  localparam int LOW_W = DATA_W - HDR_W;
  localparam logic [PAD_W-1:0]  HDR_PAD   = PAD_W'(HDR_B);
  localparam logic [PAD_W-1:0]  TAIL_PAD  = PAD_W'(BYTES - HDR_B);
  localparam logic [SIZE_W-1:0] HDR_SIZE  = SIZE_W'(HDR_B);

  typedef enum logic [2:0] {IDLE, FIRST, MID, DRAIN, ZERO} state_t;

  state_t              state;
  logic [HDR_W-1:0]    hdr_r;
  logic [HDR_W-1:0]    carry_r;
  logic [SIZE_W-1:0]   size_r;
  logic [PAD_W-1:0]    pad_r;
  logic                last_fits;

  // A last beat whose padding covers the 14 shifted-out bytes needs no drain beat
  assign last_fits = (src_eth_assemble_data_padbytes >= HDR_PAD);

  always_comb begin
    eth_assemble_src_hdr_rdy       = 1'b0;
    eth_assemble_src_data_rdy      = 1'b0;
    eth_assemble_dst_val           = 1'b0;
    eth_assemble_dst_data          = '0;
    eth_assemble_dst_data_last     = 1'b0;
    eth_assemble_dst_data_padbytes = '0;
    eth_assemble_dst_frame_size    = '0;
    if (!rst) begin
      eth_assemble_dst_frame_size = size_r + HDR_SIZE;
      case (state)
        IDLE: eth_assemble_src_hdr_rdy = 1'b1;
        FIRST, MID: begin
          eth_assemble_src_data_rdy = dst_eth_assemble_rdy;
          eth_assemble_dst_val      = src_eth_assemble_data_val;
          eth_assemble_dst_data     = {(state == FIRST) ? hdr_r : carry_r,
                                       src_eth_assemble_data[DATA_W-1:HDR_W]};
          if (src_eth_assemble_data_last && last_fits) begin
            eth_assemble_dst_data_last     = 1'b1;
            eth_assemble_dst_data_padbytes = src_eth_assemble_data_padbytes - HDR_PAD;
          end
        end
        DRAIN: begin
          eth_assemble_dst_val           = 1'b1;
          eth_assemble_dst_data          = {carry_r, {LOW_W{1'b0}}};
          eth_assemble_dst_data_last     = 1'b1;
          eth_assemble_dst_data_padbytes = pad_r + TAIL_PAD;
        end
        ZERO: begin
          eth_assemble_dst_val           = 1'b1;
          eth_assemble_dst_data          = {hdr_r, {LOW_W{1'b0}}};
          eth_assemble_dst_data_last     = 1'b1;
          eth_assemble_dst_data_padbytes = TAIL_PAD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hdr_r   <= '0;
      carry_r <= '0;
      size_r  <= '0;
      pad_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (src_eth_assemble_hdr_val) begin
            hdr_r  <= src_eth_assemble_eth_hdr;
            size_r <= src_eth_assemble_data_size;
            state  <= (src_eth_assemble_data_size == '0) ? ZERO : FIRST;
          end
        end
        FIRST, MID: begin
          if (src_eth_assemble_data_val && dst_eth_assemble_rdy) begin
            carry_r <= src_eth_assemble_data[HDR_W-1:0];
            if (!src_eth_assemble_data_last) begin
              state <= MID;
            end else if (last_fits) begin
              state <= IDLE;
            end else begin
              pad_r <= src_eth_assemble_data_padbytes;
              state <= DRAIN;
            end
          end
        end
        DRAIN, ZERO: begin
          if (dst_eth_assemble_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_frame_assemble.sv
// Scoreboard bench: a byte-stream model of each frame feeds a queue that an
// independent monitor drains on every output handshake.
module tb_eth_tx_frame_assemble;
  logic         clk = 1'b0;
  logic         rst;
  logic         hdr_val;
  logic [111:0] eth_hdr;
  logic [15:0]  data_size;
  logic         hdr_rdy;
  logic         data_val;
  logic [511:0] data;
  logic         data_last;
  logic [5:0]   data_pad;
  logic         data_rdy;
  logic         dst_val;
  logic [511:0] dst_data;
  logic [15:0]  dst_fsize;
  logic         dst_last;
  logic [5:0]   dst_pad;
  logic         dst_rdy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  bit rdy_mode = 1'b1;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [5:0]   pad;
    logic [15:0]  fsize;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  eth_tx_frame_assemble dut (
    .clk                            (clk),
    .rst                            (rst),
    .src_eth_assemble_hdr_val       (hdr_val),
    .src_eth_assemble_eth_hdr       (eth_hdr),
    .src_eth_assemble_data_size     (data_size),
    .eth_assemble_src_hdr_rdy       (hdr_rdy),
    .src_eth_assemble_data_val      (data_val),
    .src_eth_assemble_data          (data),
    .src_eth_assemble_data_last     (data_last),
    .src_eth_assemble_data_padbytes (data_pad),
    .eth_assemble_src_data_rdy      (data_rdy),
    .eth_assemble_dst_val           (dst_val),
    .eth_assemble_dst_data          (dst_data),
    .eth_assemble_dst_frame_size    (dst_fsize),
    .eth_assemble_dst_data_last     (dst_last),
    .eth_assemble_dst_data_padbytes (dst_pad),
    .dst_eth_assemble_rdy           (dst_rdy)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s act=timeout exp=handshake", name);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [111:0] rand_hdr();
    logic [511:0] r;
    r = rand512();
    return r[111:0];
  endfunction

  // Downstream ready: always high or randomly stalling
  initial begin
    dst_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dst_rdy = rdy_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on every output handshake, checks stability across stalls
  initial begin : monitor
    bit held;
    logic [511:0] h_data;
    logic [22:0]  h_ctl;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("stall_val", 512'(dst_val), 512'(1));
        chk("stall_data", dst_data, h_data);
        chk("stall_ctl", 512'({dst_last, dst_pad, dst_fsize}), 512'(h_ctl));
      end
      if (dst_val && dst_rdy) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat act=beat exp=none");
        end else begin
          e = sb.pop_front();
          chk("beat_data", dst_data, e.data);
          chk("beat_last", 512'(dst_last), 512'(e.last));
          chk("beat_pad", 512'(dst_pad), 512'(e.pad));
          chk("frame_size", 512'(dst_fsize), 512'(e.fsize));
        end
      end else if (dst_val) begin
        held   = 1'b1;
        h_data = dst_data;
        h_ctl  = {dst_last, dst_pad, dst_fsize};
      end else begin
        held = 1'b0;
      end
    end
  end

  // Frame seen as one byte stream: header, every input byte, then zero fill
  task automatic model_frame(input logic [111:0] hdr, input logic [15:0] size,
                             input logic [511:0] beats[$], input logic [5:0] lpad);
    logic [7:0] bq[$];
    int len, ob, idx;
    exp_t e;
    for (int i = 0; i < 14; i++) bq.push_back(hdr[111-8*i -: 8]);
    foreach (beats[b])
      for (int j = 0; j < 64; j++) bq.push_back(beats[b][511-8*j -: 8]);
    len = (beats.size() == 0) ? 14 : 14 + beats.size() * 64 - int'(lpad);
    ob  = (len + 63) / 64;
    for (int k = 0; k < ob; k++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) begin
        idx = k * 64 + j;
        if (idx < bq.size()) e.data[511-8*j -: 8] = bq[idx];
      end
      e.last  = (k == ob - 1);
      e.pad   = e.last ? 6'(ob * 64 - len) : 6'd0;
      e.fsize = 16'(size + 16'd14);
      sb.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [511:0] d, input logic l, input logic [5:0] p);
    bit ok;
    data_val  = 1'b1;
    data      = d;
    data_last = l;
    data_pad  = p;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (data_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("data_handshake");
    @(posedge clk);
    #1;
    data_val = 1'b0;
  endtask

  task automatic run_frame(input logic [111:0] hdr, input logic [15:0] size, input int nb,
                           input logic [5:0] lpad, input bit same_cyc, input bit gaps);
    logic [511:0] beats[$];
    bit ok;
    for (int b = 0; b < nb; b++) beats.push_back(rand512());
    model_frame(hdr, size, beats, lpad);
    hdr_val   = 1'b1;
    eth_hdr   = hdr;
    data_size = size;
    if (same_cyc && nb > 0) begin
      data_val  = 1'b1;
      data      = beats[0];
      data_last = (nb == 1);
      data_pad  = (nb == 1) ? lpad : 6'($urandom);
    end
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (hdr_rdy) begin
        ok = 1'b1;
        if (same_cyc && nb > 0) chk("hdr_data_same_cycle", 512'(data_rdy), 512'(0));
        break;
      end
    end
    if (!ok) fail_timeout("hdr_handshake");
    @(posedge clk);
    #1;
    hdr_val = 1'b0;
    if (nb == 0) begin
      data_val  = 1'b1;
      data      = rand512();
      data_last = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 1000; t++) begin
        @(negedge clk);
        chk("zero_no_data_rdy", 512'(data_rdy), 512'(0));
        if (sb.size() == 0) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_timeout("zero_frame_out");
      @(posedge clk);
      #1;
      data_val = 1'b0;
    end else begin
      for (int b = 0; b < nb; b++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          data_val = 1'b0;
          @(posedge clk);
          #1;
        end
        send_beat(beats[b], b == nb - 1, (b == nb - 1) ? lpad : 6'($urandom));
      end
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("scoreboard_drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    logic [5:0] lp;
    logic [15:0] sz;
    rst = 1'b1; hdr_val = 1'b0; eth_hdr = '0; data_size = '0;
    data_val = 1'b0; data = '0; data_last = 1'b0; data_pad = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dst_val", 512'(dst_val), 512'(0));
    chk("rst_hdr_rdy", 512'(hdr_rdy), 512'(0));
    chk("rst_data_rdy", 512'(data_rdy), 512'(0));
    chk("rst_outputs", 512'({dst_data, dst_fsize, dst_pad, dst_last}), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hdr_rdy", 512'(hdr_rdy), 512'(1));
    chk("idle_dst_val", 512'(dst_val), 512'(0));
    @(posedge clk);
    #1;

    run_frame(rand_hdr(), 16'd50, 1, 6'd14, 1'b0, 1'b0);
    run_frame(rand_hdr(), 16'd64, 1, 6'd0, 1'b0, 1'b0);
    run_frame(rand_hdr(), 16'd0, 0, 6'd0, 1'b0, 1'b0);
    run_frame(rand_hdr(), 16'd200, 4, 6'd56, 1'b0, 1'b0);
    run_frame(rand_hdr(), 16'd1, 1, 6'd63, 1'b1, 1'b0);
    run_frame(rand_hdr(), 16'hFFF8, 1, 6'd13, 1'b0, 1'b0);
    wait_drain();

    // Reset while in the middle of a frame
    mon_en    = 1'b0;
    hdr_val   = 1'b1;
    eth_hdr   = rand_hdr();
    data_size = 16'd250;
    @(posedge clk);
    #1;
    hdr_val = 1'b0;
    send_beat(rand512(), 1'b0, 6'd0);
    send_beat(rand512(), 1'b0, 6'd0);
    data_val = 1'b1;
    data     = rand512();
    rst      = 1'b1;
    @(negedge clk);
    chk("midrst_dst_val", 512'(dst_val), 512'(0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    data_val = 1'b0;
    @(negedge clk);
    chk("postrst_hdr_rdy", 512'(hdr_rdy), 512'(1));
    chk("postrst_dst_val", 512'(dst_val), 512'(0));
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    run_frame(rand_hdr(), 16'd100, 2, 6'd28, 1'b0, 1'b0);

    rdy_mode = 1'b0;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(0, 4);
      lp = 6'($urandom);
      sz = (nb == 0) ? 16'd0 : 16'(nb * 64 - int'(lp));
      if ($urandom_range(0, 7) == 0 && nb > 0) sz = 16'($urandom);
      if (sz == 16'd0 && nb > 0) sz = 16'd1;
      run_frame(rand_hdr(), sz, nb, lp, 1'($urandom), 1'($urandom));
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
